// File: rtl/booth_arb_pkg.sv
// Shared types and defaults for the Booth multiplier arbiter and its datapath core.
package booth_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 8;

    // A single requester still needs a one-bit id field.
    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/booth_step_core.sv
// Sequential radix-2 Booth datapath: load captures operands, each step does one add/sub and shift.
module booth_step_core
    import booth_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product
);

    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             qm1_q, qm1_d;
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   sum;

    always_comb begin
        // One guard bit on acc keeps the -2^(WIDTH-1) multiplicand exact when negated.
        m_ext = {m_q[WIDTH-1], m_q};
        case ({q_q[0], qm1_q})
            2'b10:   sum = acc_q - m_ext;
            2'b01:   sum = acc_q + m_ext;
            default: sum = acc_q;
        endcase

        acc_d = acc_q;
        q_d   = q_q;
        qm1_d = qm1_q;
        m_d   = m_q;
        if (load) begin
            acc_d = '0;
            q_d   = b;
            qm1_d = 1'b0;
            m_d   = a;
        end else if (step) begin
            acc_d = {sum[WIDTH], sum[WIDTH:1]};
            q_d   = {sum[0], q_q[WIDTH-1:1]};
            qm1_d = q_q[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            q_q   <= '0;
            qm1_q <= 1'b0;
            m_q   <= '0;
        end else begin
            acc_q <= acc_d;
            q_q   <= q_d;
            qm1_q <= qm1_d;
            m_q   <= m_d;
        end
    end

    assign product = {acc_q[WIDTH-1:0], q_q};

endmodule

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter sequencing a shared Booth multiplier core.
// Optional BOOTH_ARB_OPCOUNT_EN adds a saturating 16-bit completed-operation counter.
module booth_mul_arbiter
    import booth_arb_pkg::*;
#(
    parameter  int NREQ  = DEF_NREQ,
    parameter  int WIDTH = DEF_WIDTH,
    localparam int IDW   = id_width(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [2*WIDTH-1:0]    rsp_product,
    output logic                  busy
`ifdef BOOTH_ARB_OPCOUNT_EN
    ,
    output logic [15:0]           op_count
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [CW-1:0]  count_q, count_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           busy_q, busy_d;
    logic           load, step;
    logic [IDW:0]   pick;
    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [WIDTH-1:0] a_arr [NREQ];
    logic [WIDTH-1:0] b_arr [NREQ];

    // Returns {found, index} of the first valid requester at or after p, wrapping.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] v, input logic [IDW-1:0] p);
        logic [IDW:0]   r;
        logic [IDW-1:0] sel;
        r = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sel = IDW'((int'(p) + k) % NREQ);
            if (v[sel]) r = {1'b1, sel};
        end
        return r;
    endfunction

    assign pick        = rr_pick(req_valid, ptr_q);
    assign grant_found = pick[IDW];
    assign grant_idx   = pick[IDW-1:0];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign a_arr[gi]     = req_a[gi*WIDTH +: WIDTH];
            assign b_arr[gi]     = req_b[gi*WIDTH +: WIDTH];
            assign req_ready[gi] = (state_q == IDLE) && grant_found && (grant_idx == IDW'(gi));
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        count_d = count_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    load    = 1'b1;
                    id_d    = grant_idx;
                    count_d = CW'(WIDTH);
                    state_d = RUN;
                end
            end
            RUN: begin
                // The extra RUN cycle at count==0 keeps latency at WIDTH+1 edges.
                if (count_q != '0) begin
                    step    = 1'b1;
                    count_d = count_q - CW'(1);
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    ptr_d   = IDW'((int'(id_q) + 1) % NREQ);
                end
            end
            default: state_d = IDLE;
        endcase
        rsp_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            count_q     <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            count_q     <= count_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    booth_step_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (step),
        .a      (a_arr[grant_idx]),
        .b      (b_arr[grant_idx]),
        .product(rsp_product)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign busy      = busy_q;

`ifdef BOOTH_ARB_OPCOUNT_EN
    logic [15:0] op_count_q, op_count_d;

    always_comb begin
        op_count_d = op_count_q;
        if (rsp_valid_q && rsp_ready && (op_count_q != 16'hFFFF))
            op_count_d = op_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) op_count_q <= '0;
        else     op_count_q <= op_count_d;
    end

    assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Self-checking bench for booth_mul_arbiter: vector table, fairness, backpressure and reset cases.
module tb_booth_mul_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*W-1:0]     req_a;
    logic [NREQ*W-1:0]     req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [1:0]            rsp_id;
    logic [2*W-1:0]        rsp_product;
    logic                  busy;
`ifdef BOOTH_ARB_OPCOUNT_EN
    logic [15:0]           op_count;
`endif

    booth_mul_arbiter #(.NREQ(NREQ), .WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_product(rsp_product),
        .busy       (busy)
`ifdef BOOTH_ARB_OPCOUNT_EN
        ,
        .op_count   (op_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  id;
        logic [15:0] prod;
    } exp_t;

    typedef struct {
        int          req;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int i, input logic [7:0] a, input logic [7:0] b);
        req_valid = req_valid | (4'b0001 << i);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic drop_req(input int i);
        req_valid = req_valid & ~(4'b0001 << i);
    endtask

    // Drive one request, wait for its grant, record the expectation, take the accept edge.
    task automatic issue(input int i, input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
        int n = 0;
        drive_req(i, a, b);
        #1;
        while (req_ready == '0 && n < 40) begin
            tick();
            n++;
        end
        check("grant", 32'(req_ready), 32'(4'b0001 << i));
        sb.push_back('{id: 2'(i), prod: p});
        tick();
        drop_req(i);
    endtask

    // Wait for rsp_valid, check latency (if lat>0) and the scoreboard head, then handshake.
    task automatic collect(input int lat);
        int   n = 0;
        exp_t e;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
        if (lat > 0) check("latency", 32'(n), 32'(lat));
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("sb_size", 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("rsp_id", 32'(rsp_id), 32'(e.id));
            check("rsp_product", 32'(rsp_product), 32'(e.prod));
            $display("txn id=%0d product=%0d (expected id=%0d product=%0d)",
                     rsp_id, $signed(rsp_product), e.id, $signed(e.prod));
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  fa [4];
        logic [7:0]  fb [4];
        logic [15:0] bp_prod;
        logic [1:0]  bp_id;
        int          g, n, seen;

        vecs[0] = '{0, 8'd12,   8'd10,   16'h0078};
        vecs[1] = '{1, 8'hF4,   8'd10,   16'hFF88};
        vecs[2] = '{2, 8'h80,   8'h80,   16'h4000};
        vecs[3] = '{3, 8'h7F,   8'h80,   16'hC080};
        vecs[4] = '{0, 8'h00,   8'hB3,   16'h0000};
        vecs[5] = '{1, 8'hFF,   8'hFF,   16'h0001};
        vecs[6] = '{2, 8'h80,   8'h7F,   16'hC080};
        vecs[7] = '{3, 8'h4D,   8'hFD,   16'hFF19};
        fa = '{8'd3, 8'hEC, 8'd100, 8'h80};
        fb = '{8'd7, 8'd9,  8'hFB,  8'h7F};

        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
        check("reset_rsp_product", 32'(rsp_product), 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd0);
`ifdef BOOTH_ARB_OPCOUNT_EN
        check("reset_op_count", 32'(op_count), 32'd0);
`endif

        for (int k = 0; k < 8; k++) begin
            issue(vecs[k].req, vecs[k].a, vecs[k].b, vecs[k].prod);
            check("busy_run", 32'(busy), 32'd1);
            collect(9);
        end

        // Fairness: all four requesters held valid, ptr starts at 0 after reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) drive_req(i, fa[i], fb[i]);
        #1;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (req_ready == '0 && n < 40) begin
                tick();
                n++;
            end
            g = -1;
            for (int i = 0; i < 4; i++) if (req_ready[i]) g = i;
            check("rr_order", 32'(g), 32'(k % 4));
            if (g >= 0)
                sb.push_back('{id: 2'(g), prod: 16'($signed(fa[g]) * $signed(fb[g]))});
            tick();
            collect(9);
        end
        req_valid = '0;

        // Backpressure: hold DONE for 5 cycles with a competing request pending.
        issue(1, 8'h9C, 8'd3, 16'hFED4);
        n = 0;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
        bp_prod = rsp_product;
        bp_id   = rsp_id;
        drive_req(3, 8'd5, 8'd5);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_product", 32'(rsp_product), 32'(bp_prod));
            check("bp_id", 32'(rsp_id), 32'(bp_id));
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        drop_req(3);
        #1;
        collect(0);
        check("bp_idle_after", 32'(busy), 32'd0);

        // Reset mid-RUN: first leave ptr at 3, then reset and show ptr back at 0.
        issue(2, 8'd5, 8'd6, 16'd30);
        collect(9);
        issue(0, 8'd3, 8'd3, 16'd9);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_product", 32'(rsp_product), 32'd0);
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            if (rsp_valid) seen++;
            tick();
        end
        check("rst_no_rsp", 32'(seen), 32'd0);
        drive_req(1, 8'd1, 8'd1);
        drive_req(3, 8'd1, 8'd1);
        #1;
        check("rst_ptr_zero", 32'(req_ready), 32'(4'b0010));
        req_valid = '0;
        #1;
        issue(2, 8'hF9, 8'd9, 16'hFFC1);
        collect(9);
        issue(0, 8'd11, 8'd11, 16'd121);
        collect(9);
        issue(3, 8'h80, 8'hFF, 16'd128);
        collect(9);
`ifdef BOOTH_ARB_OPCOUNT_EN
        check("op_count_3", 32'(op_count), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("op_count_reset", 32'(op_count), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
